// File: rtl/sprite_pkg.sv
// Shared types and constants for the alien sprite renderer.
// Holds sprite geometry, the FSM state encoding and the row bit-reversal helper.
package sprite_pkg;

    localparam int SPRITE_W = 10;
    localparam int SPRITE_H = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ARMED = 2'd2,
        DRAW  = 2'd3
    } sprite_state_e;

    function automatic logic [9:0] bitrev10(input logic [9:0] v);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) begin
            r[i] = v[9-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// Holds one latched sprite row and presents its leftmost pixel on msb.
// Priority: reset/clear, then load, then shift-left.
module sprite_row_shifter
    import sprite_pkg::*;
#(
    parameter int W = SPRITE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    output logic         msb
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sh_q <= '0;
        end else if (load) begin
            sh_q <= load_data;
        end else if (shift_en) begin
            sh_q <= {sh_q[W-2:0], 1'b0};
        end
    end

    assign msb = sh_q[W-1];

endmodule

// File: rtl/alien_sprite_renderer.sv
// Fetches one sprite row per scanline during hblank and streams it out as pixel_on.
// Optional ALIEN_FLIP_EN adds a flip_x input that mirrors the sprite horizontally.
module alien_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SCALE_LOG2 = 1,
    parameter int H_ACTIVE   = 640,
    parameter int V_TOTAL    = 525,
    parameter int COORD_W    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COORD_W-1:0]  hpos,
    input  logic [COORD_W-1:0]  vpos,
    input  logic                line_start,
    input  logic                enable,
    input  logic [COORD_W-1:0]  sprite_x,
    input  logic [COORD_W-1:0]  sprite_y,
    output logic [3:0]          rom_row_index,
    input  logic [SPRITE_W-1:0] rom_row_data,
    output logic                pixel_on,
`ifdef ALIEN_FLIP_EN
    input  logic                flip_x,
`endif
    output logic [1:0]          dbg_state
);

    localparam int SCALE = 1 << SCALE_LOG2;
    localparam int SUB_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam int COL_W = $clog2(SPRITE_W);

    localparam logic [COORD_W-1:0] SPAN     = COORD_W'(SPRITE_H << SCALE_LOG2);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(H_ACTIVE);
    localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(SPRITE_W - 1);

    sprite_state_e state_q, state_d;

    logic [COORD_W-1:0] next_line, dy, x_q;
    logic [3:0]         row_sel;
    logic               hit, in_active, flip_in, flip_q;
    logic [SUB_W-1:0]   sub_q;
    logic [COL_W-1:0]   col_q;
    logic               sh_clear, sh_load, sh_shift, sh_msb;
    logic               draw_cyc, sub_wrap, last_cyc;
    logic [SPRITE_W-1:0] load_data;

`ifdef ALIEN_FLIP_EN
    assign flip_in = flip_x;
`else
    assign flip_in = 1'b0;
`endif

    // The row fetched now is for the line after vpos, wrapping at frame end.
    assign next_line = (vpos == V_LAST) ? '0 : vpos + 1'b1;
    assign dy        = next_line - sprite_y;
    assign hit       = enable && (dy < SPAN);
    assign row_sel   = 4'(dy >> SCALE_LOG2);
    assign in_active = hpos < H_LIM;
    assign load_data = flip_q ? bitrev10(rom_row_data) : rom_row_data;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // line_start outranks everything: it aborts any line in progress and re-evaluates.
    always_comb begin
        state_d  = state_q;
        sh_clear = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        draw_cyc = 1'b0;
        sub_wrap = 1'b0;
        last_cyc = 1'b0;
        if (line_start) begin
            state_d  = hit ? FETCH : IDLE;
            sh_clear = !hit;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                FETCH: begin
                    sh_load = 1'b1;
                    state_d = ARMED;
                end
                ARMED: begin
                    if (in_active && (hpos == x_q)) begin
                        draw_cyc = 1'b1;
                        state_d  = DRAW;
                    end
                end
                DRAW: begin
                    if (in_active) begin
                        draw_cyc = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (draw_cyc) begin
                sub_wrap = (sub_q == SUB_LAST);
                sh_shift = sub_wrap;
                last_cyc = sub_wrap && (col_q == COL_LAST);
                if (last_cyc) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= '0;
            flip_q        <= 1'b0;
            sub_q         <= '0;
            col_q         <= '0;
            rom_row_index <= '0;
            pixel_on      <= 1'b0;
        end else begin
            pixel_on <= draw_cyc & sh_msb;
            if (line_start) begin
                sub_q <= '0;
                col_q <= '0;
                if (hit) begin
                    x_q           <= sprite_x;
                    flip_q        <= flip_in;
                    rom_row_index <= row_sel;
                end
            end else if (draw_cyc) begin
                if (sub_wrap) begin
                    sub_q <= '0;
                    col_q <= col_q + 1'b1;
                end else begin
                    sub_q <= sub_q + 1'b1;
                end
            end
        end
    end

    sprite_row_shifter #(.W(SPRITE_W)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .clear     (sh_clear),
        .load      (sh_load),
        .load_data (load_data),
        .shift_en  (sh_shift),
        .msb       (sh_msb)
    );

endmodule

// File: tb/tb_alien_sprite_renderer.sv
// Bench for alien_sprite_renderer: directed scanlines, a per-cycle reference model
// computing each line's expected pixels from the ROM contents and sprite geometry.
module tb_alien_sprite_renderer;

    localparam int H_ACTIVE = 640;
    localparam int H_TOTAL  = 660;
    localparam int V_TOTAL  = 525;
    localparam int SCALE    = 2;
    localparam int SPAN_PIX = 10 * SCALE;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       line_start = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] sprite_x = '0;
    logic [9:0] sprite_y = '0;
    logic [3:0] rom_row_index;
    logic [9:0] rom_row_data;
    logic       pixel_on;
    logic [1:0] dbg_state;
`ifdef ALIEN_FLIP_EN
    logic       flip_x = 1'b0;
`endif

    logic [9:0] rom [0:15];
    assign rom_row_data = rom[rom_row_index];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alien_sprite_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .hpos          (hpos),
        .vpos          (vpos),
        .line_start    (line_start),
        .enable        (enable),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .rom_row_index (rom_row_index),
        .rom_row_data  (rom_row_data),
        .pixel_on      (pixel_on),
`ifdef ALIEN_FLIP_EN
        .flip_x        (flip_x),
`endif
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;
    bit         m_pend, m_active;
    int         m_pend_cyc, m_c0, m_x;
    logic [9:0] m_bits;
    int         exp_pix = 0;
    int         exp_idx = 0;

    always @(posedge clk) begin
        int nl, row, k;
        logic [9:0] dy, raw;
        cyc++;
        if (reset) begin
            m_pend = 0; m_active = 0; exp_pix = 0; exp_idx = 0;
        end else if (line_start) begin
            nl = (int'(vpos) == V_TOTAL - 1) ? 0 : int'(vpos) + 1;
            dy = 10'(nl - int'(sprite_y));
            m_active = 0;
            exp_pix  = 0;
            if (enable && int'(dy) < SPAN_PIX) begin
                row        = int'(dy) / SCALE;
                raw        = rom[row];
                m_bits     = raw;
`ifdef ALIEN_FLIP_EN
                if (flip_x) for (int i = 0; i < 10; i++) m_bits[i] = raw[9-i];
`endif
                m_pend     = 1;
                m_pend_cyc = cyc + 2;
                m_x        = int'(sprite_x);
                exp_idx    = row;
            end else begin
                m_pend = 0;
            end
        end else if (m_active) begin
            if (int'(hpos) >= H_ACTIVE) begin
                m_active = 0;
                exp_pix  = 0;
            end else begin
                k       = cyc - m_c0;
                exp_pix = int'(m_bits[9 - k / SCALE]);
                if (k == SPAN_PIX - 1) m_active = 0;
            end
        end else if (m_pend && cyc >= m_pend_cyc && int'(hpos) == m_x && int'(hpos) < H_ACTIVE) begin
            m_pend   = 0;
            m_active = 1;
            m_c0     = cyc;
            exp_pix  = int'(m_bits[9]);
            if (SPAN_PIX == 1) m_active = 0;
        end else begin
            exp_pix = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pixel_on", int'(pixel_on), exp_pix);
            check("model_rom_row_index", int'(rom_row_index), exp_idx);
        end
    end

    // ---------------- driver ----------------
    int on_cnt, first_h, last_h;

    task automatic run_line(input int v, input int ls_h, input int rst_h);
        on_cnt = 0; first_h = -1; last_h = -1;
        for (int h = 0; h < H_TOTAL; h++) begin
            hpos       = 10'(h);
            vpos       = 10'(v);
            line_start = (h == H_ACTIVE) || (h == ls_h);
            reset      = (h == rst_h);
            @(posedge clk);
            @(negedge clk);
            if (pixel_on) begin
                on_cnt++;
                if (first_h < 0) first_h = h;
                last_h = h;
            end
            if (h == ls_h) check("abort_linestart_px", int'(pixel_on), 0);
            if (h == rst_h) check("abort_reset_px", int'(pixel_on), 0);
        end
        line_start = 1'b0;
        reset      = 1'b0;
    endtask

    initial begin
        rom[0]  = 10'b0011111100;
        rom[1]  = 10'b1111000011;
        rom[2]  = 10'b1000000001;
        rom[3]  = 10'b1111111111;
        rom[4]  = 10'b0110011001;
        rom[5]  = 10'b0010010010;
        rom[6]  = 10'b0000000001;
        rom[7]  = 10'b1000000000;
        rom[8]  = 10'b0101010101;
        rom[9]  = 10'b1010101010;
        for (int i = 10; i < 16; i++) rom[i] = '0;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rom_row_index", int'(rom_row_index), 0);
        check("reset_pixel_on", int'(pixel_on), 0);
        check("reset_state", int'(dbg_state), 0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Row fetch and scaled draw of row 0 at x=200.
        enable = 1'b1; sprite_x = 10'd200; sprite_y = 10'd100;
        run_line(103, -1, -1);
        check("row_idx_v103", int'(rom_row_index), 2);
        run_line(99, -1, -1);
        check("row_idx_v99", int'(rom_row_index), 0);
        run_line(100, -1, -1);
        check("draw_row0_count", on_cnt, 12);
        check("draw_row0_first", first_h, 204);
        run_line(101, -1, -1);
        check("row_idx_v101", int'(rom_row_index), 1);

        // Last row, then the sprite's bottom edge.
        run_line(118, -1, -1);
        check("row_idx_v118", int'(rom_row_index), 9);
        run_line(119, -1, -1);
        check("row_idx_held_v119", int'(rom_row_index), 9);
        check("draw_row9_count", on_cnt, 10);
        check("draw_row9_first", first_h, 200);
        run_line(120, -1, -1);
        check("below_sprite_count", on_cnt, 0);

        // Right-edge clip.
        sprite_x = 10'd630;
        run_line(105, -1, -1);
        check("row_idx_v105", int'(rom_row_index), 3);
        enable = 1'b0;
        run_line(106, -1, -1);
        check("clip_count", on_cnt, 10);
        check("clip_first", first_h, 630);
        check("clip_last", last_h, 639);
        check("clip_state_idle", int'(dbg_state), 0);

        // Frame wrap: line 524 prepares line 0.
        enable = 1'b1; sprite_x = 10'd300; sprite_y = 10'd0;
        run_line(524, -1, -1);
        check("wrap_row_idx", int'(rom_row_index), 0);
        sprite_x = 10'd200;
        run_line(0, -1, -1);
        check("wrap_draw_count", on_cnt, 12);
        check("wrap_draw_first", first_h, 304);

        // Abort mid-draw by line_start, then by reset.
        run_line(1, 206, -1);
        check("abort_ls_count", on_cnt, 2);
        run_line(2, -1, 203);
        check("abort_rst_count", on_cnt, 3);
        check("after_rst_row_idx", int'(rom_row_index), 1);
        run_line(3, -1, -1);
        check("after_rst_count", on_cnt, 12);
        check("after_rst_first", first_h, 200);

`ifdef ALIEN_FLIP_EN
        flip_x = 1'b1;
        run_line(9, -1, -1);
        check("flip_row_idx", int'(rom_row_index), 5);
        flip_x = 1'b0;
        run_line(10, -1, -1);
        check("flip_count", on_cnt, 6);
        check("flip_first", first_h, 202);
        check("flip_last", last_h, 215);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
